dbuf_rd_streamer: RTL and testbench



---
 rtl/dbuf_rd_streamer_if.sv | 36 +++
 rtl/dbuf_rd_streamer.sv | 214 +++++++++++++++++++++
 tb/tb_dbuf_rd_streamer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dbuf_rd_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module   : dbuf_rd_streamer_if
//  Brief    : Bundle between the reader streamer, the double-buffer read port
//             and the downstream valid/ready word stream.
//  Revision : 1.0 - initial release
// ============================================================================
interface dbuf_rd_streamer_if #(
  parameter int P_RD_ADDR_WIDTH = 9,
  parameter int P_RD_DATA_WIDTH = 64
);
  // Double-buffer read side
  logic                       buf_rd_busy;
  logic [15:0]                buf_dpram_len;
  logic [P_RD_ADDR_WIDTH-1:0] buf_rd_addr;
  logic [P_RD_DATA_WIDTH-1:0] buf_rd_dout;
  logic                       buf_done;
  // Downstream word stream
  logic [P_RD_DATA_WIDTH-1:0] dout;
  logic                       dout_valid;
  logic                       dout_ready;
  logic                       dout_last;

  // master: the streamer itself
  modport master (
    input  buf_rd_busy, buf_dpram_len, buf_rd_dout, dout_ready,
    output buf_rd_addr, buf_done, dout, dout_valid, dout_last
  );

  // slave: the double buffer plus the stream consumer
  modport slave (
    output buf_rd_busy, buf_dpram_len, buf_rd_dout, dout_ready,
    input  buf_rd_addr, buf_done, dout, dout_valid, dout_last
  );
endinterface
`default_nettype wire

// File: rtl/dbuf_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : dbuf_rd_streamer
//  Brief    : Waits for a filled double-buffer half, reads it out sequentially
//             with credit-based flow control into a small fall-through FIFO,
//             streams the words with last marking and releases the buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module dbuf_rd_streamer #(
  parameter int P_RD_ADDR_WIDTH = 9,
  parameter int P_RD_DATA_WIDTH = 64,
  parameter int P_RD_LATENCY    = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  dbuf_rd_streamer_if.master bus,
  output logic [15:0]        page_len,
  output logic [15:0]        pages_done,
  output logic               len_err
);

  localparam int c_depth = P_RD_LATENCY + 2;
  localparam int c_ptr_w = (c_depth > 1) ? $clog2(c_depth) : 1;
  localparam int c_cnt_w = $clog2(c_depth + 1);
  localparam int c_aw1   = P_RD_ADDR_WIDTH + 1;
  localparam int c_fw    = P_RD_DATA_WIDTH + 1;   // data plus last tag
  localparam logic [16:0] c_max_len = 17'd1 << P_RD_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_DRAIN   = 3'd2,
    S_DONE    = 3'd3,
    S_RELEASE = 3'd4,
    S_SETTLE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic                 err_q, err_d;
  logic [15:0]          pages_q, pages_d;
  logic [c_aw1-1:0]     addr_q, addr_d;
  logic [P_RD_LATENCY-1:0] vld_q, vld_d;
  logic [P_RD_LATENCY-1:0] tag_q, tag_d;
  logic [c_fw-1:0]      mem_q [c_depth];
  logic [c_fw-1:0]      mem_d [c_depth];
  logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;

  logic                 w_issue;
  logic                 w_issue_last;
  logic [c_aw1-1:0]     w_addr_nxt;
  logic [3:0]           w_inflight;
  logic [3:0]           w_occ;
  logic                 w_credit;
  logic                 w_push;
  logic                 w_push_last;
  logic                 w_pop;
  logic                 w_valid;
  logic [c_fw-1:0]      w_head;
  logic                 w_head_last;
  logic                 w_len_over;
  logic [15:0]          w_len_clamped;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(c_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_len_over    = {1'b0, bus.buf_dpram_len} > c_max_len;
  assign w_len_clamped = w_len_over ? c_max_len[15:0] : bus.buf_dpram_len;
  assign w_addr_nxt    = addr_q + 1'b1;
  assign w_issue_last  = (16'(w_addr_nxt) == len_q);

  assign w_valid     = (cnt_q != '0);
  assign w_head      = mem_q[rd_ptr_q];
  assign w_head_last = w_head[P_RD_DATA_WIDTH];
  assign w_pop       = w_valid & bus.dout_ready;
  assign w_push      = vld_q[P_RD_LATENCY-1];
  assign w_push_last = tag_q[P_RD_LATENCY-1];

  // Reads still travelling through the DPRAM latency pipeline
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < P_RD_LATENCY; i++) begin
      w_inflight = w_inflight + {3'b000, vld_q[i]};
    end
  end

  // Conservative credit: every read in flight must already own a FIFO slot
  assign w_occ    = w_inflight + 4'(cnt_q);
  assign w_credit = (w_occ < 4'(c_depth));

  // Page sequencing: latch length, issue reads, drain, release the buffer
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    err_d   = err_q;
    pages_d = pages_q;
    addr_d  = addr_q;
    w_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.buf_rd_busy) begin
          len_d   = w_len_clamped;
          err_d   = err_q | w_len_over;
          addr_d  = '0;
          state_d = (w_len_clamped == 16'd0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (w_credit) begin
          w_issue = 1'b1;
          addr_d  = w_addr_nxt;
          if (w_issue_last) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        pages_d = pages_q + 16'd1;
        addr_d  = '0;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!bus.buf_rd_busy) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read-latency shift register carrying the valid and last-word tags
  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = w_issue;
    tag_d[0] = w_issue & w_issue_last;
    for (int i = 1; i < P_RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  // Fall-through output FIFO bookkeeping
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = {w_push_last, bus.buf_rd_dout};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (w_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      err_q    <= 1'b0;
      pages_q  <= '0;
      addr_q   <= '0;
      vld_q    <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < c_depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      err_q    <= err_d;
      pages_q  <= pages_d;
      addr_q   <= addr_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  // After the final issue of a full-size page the counter sits at 2^W;
  // hold the visible address at the top instead of showing a wrap to 0.
  assign bus.buf_rd_addr = addr_q[P_RD_ADDR_WIDTH] ? '1 : addr_q[P_RD_ADDR_WIDTH-1:0];
  assign bus.buf_done    = (state_q == S_DONE);
  assign bus.dout        = w_valid ? w_head[P_RD_DATA_WIDTH-1:0] : '0;
  assign bus.dout_valid  = w_valid;
  assign bus.dout_last   = w_valid & w_head_last;
  assign page_len        = len_q;
  assign pages_done      = pages_q;
  assign len_err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dbuf_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbuf_rd_streamer
//  Brief    : Self-checking bench: double-buffer/DPRAM model, scoreboard of
//             expected stream words, page vector table and corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dbuf_rd_streamer;

  localparam int AW    = 9;
  localparam int DW    = 64;
  localparam int LAT   = 2;
  localparam int DEPTH = LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dbuf_rd_streamer_if #(.P_RD_ADDR_WIDTH(AW), .P_RD_DATA_WIDTH(DW)) bus ();
  logic [15:0] page_len;
  logic [15:0] pages_done;
  logic        len_err;

  dbuf_rd_streamer #(
    .P_RD_ADDR_WIDTH(AW),
    .P_RD_DATA_WIDTH(DW),
    .P_RD_LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .page_len  (page_len),
    .pages_done(pages_done),
    .len_err   (len_err)
  );

  typedef struct { logic [63:0] data; logic last; } exp_t;
  typedef struct { int len; logic [63:0] base; } page_t;
  typedef struct {
    int          len;
    logic [63:0] base;
    int          mode;
    int          exp_words;
    int          exp_plen;
    logic        exp_err;
  } vec_t;

  exp_t        exp_q[$];
  page_t       pend_q[$];
  logic [63:0] mem [2][512];
  vec_t        vt [5];

  int tests = 0;
  int failed = 0;
  int half = 1;
  int idle_cnt = 0;
  int p1 = 0;
  int p2 = 0;
  int rmode = 0;
  int tick_n = 0;
  int words = 0;
  int dones = 0;
  int occ_max = 0;
  int exp_pages = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Double buffer hands over the next filled half
  task automatic load_page();
    page_t p;
    int    n;
    p    = pend_q.pop_front();
    half = 1 - half;
    n    = (p.len > 512) ? 512 : p.len;
    for (int i = 0; i < 512; i++) mem[half][i] = p.base + 64'(i);
    for (int i = 0; i < n; i++) exp_q.push_back('{p.base + 64'(i), (i == n - 1)});
    bus.buf_dpram_len = 16'(p.len);
    bus.buf_rd_busy   = 1'b1;
  endtask

  task automatic db_step();
    if (rst) begin
      bus.buf_rd_busy = 1'b0;
      pend_q.delete();
      exp_q.delete();
      half     = 1;
      idle_cnt = 0;
    end else if (bus.buf_done) begin
      bus.buf_rd_busy = 1'b0;
      idle_cnt        = 0;
    end else if (!bus.buf_rd_busy) begin
      idle_cnt++;
      if (idle_cnt >= 2 && pend_q.size() > 0) load_page();
    end
  endtask

  // One clock: drive inputs, model the DPRAM, score the stream
  task automatic tick();
    exp_t e;
    int   occ;
    @(negedge clk);
    tick_n++;
    case (rmode)
      1:       bus.dout_ready = (tick_n % 2 == 0);
      2:       bus.dout_ready = 1'($urandom_range(0, 1));
      default: bus.dout_ready = 1'b1;
    endcase
    bus.buf_rd_dout = mem[half][p2];
    p2 = p1;
    p1 = int'(bus.buf_rd_addr);
    occ = int'(dut.w_inflight) + int'(dut.cnt_q);
    if (occ > occ_max) occ_max = occ;
    if (bus.dout_valid && bus.dout_ready) begin
      words++;
      check("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dout", bus.dout, e.data);
        check("dout_last", bus.dout_last, e.last);
      end
    end
    if (bus.buf_done) dones++;
    db_step();
  endtask

  task automatic run_pages(input string name, input int n, input int ew, input int eplen,
                           input logic eerr);
    words   = 0;
    dones   = 0;
    occ_max = 0;
    for (int t = 0; t < 5000 && dones < n; t++) tick();
    repeat (6) tick();
    exp_pages += n;
    check({name, "_done_cnt"}, dones, n);
    check({name, "_words"}, words, ew);
    check({name, "_leftover"}, exp_q.size(), 0);
    check({name, "_page_len"}, page_len, eplen);
    check({name, "_len_err"}, len_err, eerr);
    check({name, "_pages_done"}, pages_done, exp_pages);
    check({name, "_occupancy_ok"}, occ_max <= DEPTH, 1);
    check({name, "_idle_valid"}, bus.dout_valid, 0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_addr"}, bus.buf_rd_addr, 0);
    check({name, "_done"}, bus.buf_done, 0);
    check({name, "_dout"}, bus.dout, 0);
    check({name, "_valid"}, bus.dout_valid, 0);
    check({name, "_last"}, bus.dout_last, 0);
    check({name, "_page_len"}, page_len, 0);
    check({name, "_pages_done"}, pages_done, 0);
    check({name, "_len_err"}, len_err, 0);
  endtask

  initial begin
    bus.buf_rd_busy   = 1'b0;
    bus.buf_dpram_len = '0;
    bus.buf_rd_dout   = '0;
    bus.dout_ready    = 1'b0;
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 512; i++) mem[h][i] = '0;

    vt[0] = '{1,   64'h1000, 0, 1,   1,   1'b0};
    vt[1] = '{512, 64'h2000, 1, 512, 512, 1'b0};
    vt[2] = '{0,   64'h3000, 0, 0,   0,   1'b0};
    vt[3] = '{17,  64'h4000, 2, 17,  17,  1'b0};
    vt[4] = '{700, 64'h5000, 0, 512, 512, 1'b1};

    rst = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    repeat (3) tick();

    // len=4 cycle-exact: page presented in cycle 0
    rmode = 0;
    words = 0;
    dones = 0;
    pend_q.push_back('{4, 64'hA0});
    tick();
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c <= 4) check($sformatf("t4_addr_c%0d", c), bus.buf_rd_addr, c - 1);
      check($sformatf("t4_valid_c%0d", c), bus.dout_valid, (c >= 4 && c <= 7));
      check($sformatf("t4_last_c%0d", c), bus.dout_last, (c == 7));
      check($sformatf("t4_done_c%0d", c), bus.buf_done, (c == 8));
    end
    repeat (6) tick();
    exp_pages = 1;
    check("t4_words", words, 4);
    check("t4_done_cnt", dones, 1);
    check("t4_pages_done", pages_done, 1);
    check("t4_page_len", page_len, 4);

    // Table of single pages
    for (int i = 0; i < 5; i++) begin
      rmode = vt[i].mode;
      pend_q.push_back('{vt[i].len, vt[i].base});
      run_pages($sformatf("vec%0d", i), 1, vt[i].exp_words, vt[i].exp_plen, vt[i].exp_err);
    end

    // Both halves filled back-to-back
    rmode = 2;
    pend_q.push_back('{3, 64'h300});
    pend_q.push_back('{5, 64'h500});
    run_pages("b2b", 2, 8, 5, 1'b1);

    // Reset in the middle of a page
    rmode = 0;
    words = 0;
    pend_q.push_back('{40, 64'h6000});
    for (int t = 0; t < 200 && words < 10; t++) tick();
    check("mid_reached_10", words >= 10, 1);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    exp_pages = 0;
    repeat (2) tick();
    pend_q.push_back('{2, 64'h7000});
    run_pages("post_rst", 1, 2, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
